// File: rtl/branch_unit_bht.sv
// Branch resolve unit with a bimodal history table feeding fetch predictions.
// Latency: resolve result is registered, valid one cycle after acceptance; lookup is combinational.
// Backpressure: none; one resolve per cycle, flush kills the request presented that cycle.
package branch_unit_bht_pkg;
  typedef enum logic [2:0] {
    i_BEQ  = 3'b000,
    i_BNE  = 3'b001,
    i_BLT  = 3'b100,
    i_BGE  = 3'b101,
    i_BLTU = 3'b110,
    i_BGEU = 3'b111
  } br_op_t;
endpackage

module branch_unit_bht
  import branch_unit_bht_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [XLEN-1:0]  lookup_pc,
  output logic             lookup_taken,
  input  logic             res_valid,
  input  br_op_t           res_br_op,
  input  logic [XLEN-1:0]  res_rs1_data,
  input  logic [XLEN-1:0]  res_rs2_data,
  input  logic [XLEN-1:0]  res_imm_b,
  input  logic [XLEN-1:0]  res_pc,
  input  logic             res_pred_taken,
  input  logic             flush,
  output logic             done,
  output logic             taken,
  output logic             mispredict,
  output logic [XLEN-1:0]  redirect_pc,
  output logic [CNT_W-1:0] perf_branches,
  output logic [CNT_W-1:0] perf_mispred
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  logic [1:0]       bht [BHT_ENTRIES];
  logic [IDX_W-1:0] lookup_idx;
  logic [IDX_W-1:0] res_idx;
  logic             accept;
  logic             legal_op;
  logic             cond_taken;
  logic             cond_mispred;
  logic [XLEN-1:0]  target_pc;
  logic [XLEN-1:0]  next_pc;

  // Only the word-index bits of the fetch PC select a counter.
  logic unused_lookup_bits;
  assign unused_lookup_bits = ^{lookup_pc[XLEN-1:IDX_W+2], lookup_pc[1:0]};

  assign lookup_idx   = lookup_pc[IDX_W+1:2];
  assign res_idx      = res_pc[IDX_W+1:2];
  assign lookup_taken = bht[lookup_idx][1];
  assign accept       = res_valid && !flush;
  assign target_pc    = res_pc + res_imm_b;
  assign next_pc      = res_pc + XLEN'(4);
  assign cond_mispred = cond_taken != res_pred_taken;

  // Evaluate the branch condition; unknown encodings resolve as not taken.
  always_comb begin
    legal_op   = 1'b1;
    cond_taken = 1'b0;
    case (res_br_op)
      i_BEQ:   cond_taken = res_rs1_data == res_rs2_data;
      i_BNE:   cond_taken = res_rs1_data != res_rs2_data;
      i_BLT:   cond_taken = $signed(res_rs1_data) <  $signed(res_rs2_data);
      i_BGE:   cond_taken = $signed(res_rs1_data) >= $signed(res_rs2_data);
      i_BLTU:  cond_taken = res_rs1_data <  res_rs2_data;
      i_BGEU:  cond_taken = res_rs1_data >= res_rs2_data;
      default: legal_op   = 1'b0;
    endcase
  end

  // Result stage: done pulses per accepted request, other fields hold when idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      done        <= 1'b0;
      taken       <= 1'b0;
      mispredict  <= 1'b0;
      redirect_pc <= '0;
    end else begin
      done <= accept;
      if (accept) begin
        taken       <= cond_taken;
        mispredict  <= cond_mispred;
        redirect_pc <= cond_taken ? target_pc : next_pc;
      end
    end
  end

  // Counter table: reset to weakly not-taken, saturating train on legal resolves.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= 2'b01;
    end else if (accept && legal_op) begin
      if (cond_taken && bht[res_idx] != 2'b11)
        bht[res_idx] <= bht[res_idx] + 2'b01;
      else if (!cond_taken && bht[res_idx] != 2'b00)
        bht[res_idx] <= bht[res_idx] - 2'b01;
    end
  end

  // Performance counters advance alongside done and stick at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_branches <= '0;
      perf_mispred  <= '0;
    end else if (accept) begin
      if (legal_op && perf_branches != '1) perf_branches <= perf_branches + 1'b1;
      if (cond_mispred && perf_mispred != '1) perf_mispred <= perf_mispred + 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_unit_bht.sv
module tb_branch_unit_bht;
  import branch_unit_bht_pkg::*;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;  // narrow so saturation is reached with a handful of branches

  logic             clk = 1'b0;
  logic             reset;
  logic [XLEN-1:0]  lookup_pc;
  logic             lookup_taken;
  logic             res_valid;
  br_op_t           res_br_op;
  logic [XLEN-1:0]  res_rs1_data, res_rs2_data, res_imm_b, res_pc;
  logic             res_pred_taken;
  logic             flush;
  logic             done, taken, mispredict;
  logic [XLEN-1:0]  redirect_pc;
  logic [CNT_W-1:0] perf_branches, perf_mispred;

  int checks = 0;
  int errors = 0;

  branch_unit_bht #(.XLEN(XLEN), .BHT_ENTRIES(64), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .lookup_pc(lookup_pc), .lookup_taken(lookup_taken),
    .res_valid(res_valid), .res_br_op(res_br_op),
    .res_rs1_data(res_rs1_data), .res_rs2_data(res_rs2_data),
    .res_imm_b(res_imm_b), .res_pc(res_pc),
    .res_pred_taken(res_pred_taken), .flush(flush),
    .done(done), .taken(taken), .mispredict(mispredict),
    .redirect_pc(redirect_pc),
    .perf_branches(perf_branches), .perf_mispred(perf_mispred)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input br_op_t op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm, input logic [31:0] pc, input logic pred);
    res_valid      = 1'b1;
    res_br_op      = op;
    res_rs1_data   = a;
    res_rs2_data   = b;
    res_imm_b      = imm;
    res_pc         = pc;
    res_pred_taken = pred;
  endtask

  task automatic idle();
    res_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic chk_res(input string tag, input logic t, input logic m, input logic [31:0] rpc);
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_taken"}, {31'd0, taken}, {31'd0, t});
    chk({tag, "_mispred"}, {31'd0, mispredict}, {31'd0, m});
    chk({tag, "_rpc"}, redirect_pc, rpc);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; lookup_pc = '0;
    res_valid = 1'b0; res_br_op = i_BEQ; res_rs1_data = '0; res_rs2_data = '0;
    res_imm_b = '0; res_pc = '0; res_pred_taken = 1'b0;
    step(); step();
    reset = 1'b0;

    // 1: reset state, every counter weakly not-taken
    for (int i = 0; i < 64; i++) begin
      lookup_pc = 32'(4 * i);
      #1;
      chk("rst_lookup", {31'd0, lookup_taken}, 32'd0);
    end
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_perf_br", {28'd0, perf_branches}, 32'd0);
    chk("rst_perf_mp", {28'd0, perf_mispred}, 32'd0);

    // 2: signed vs unsigned less-than on -1 vs 1
    drive(i_BLT, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h200, 1'b0);
    step();
    chk_res("blt", 1'b1, 1'b1, 32'h220);
    drive(i_BLTU, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h200, 1'b0);
    step();
    chk_res("bltu", 1'b0, 1'b0, 32'h204);
    idle();
    step();
    chk("idle_done", {31'd0, done}, 32'd0);
    chk("idle_rpc_hold", redirect_pc, 32'h204);

    // 3: train one entry to saturation, read-before-write lookup
    do_reset();
    lookup_pc = 32'h100;
    drive(i_BEQ, 32'd5, 32'd5, 32'd8, 32'h100, 1'b0);
    #1;
    chk("rbw_pre", {31'd0, lookup_taken}, 32'd0);
    step();
    chk("train1", {31'd0, lookup_taken}, 32'd1);
    chk_res("beq1", 1'b1, 1'b1, 32'h108);
    step();
    chk("train2", {31'd0, lookup_taken}, 32'd1);
    step();
    chk("train3", {31'd0, lookup_taken}, 32'd1);
    drive(i_BNE, 32'd5, 32'd5, 32'd8, 32'h100, 1'b0);
    step();
    chk("untrain1", {31'd0, lookup_taken}, 32'd1);
    step();
    chk("untrain2", {31'd0, lookup_taken}, 32'd0);
    idle();
    step();
    chk("t3_perf_br", {28'd0, perf_branches}, 32'd5);
    chk("t3_perf_mp", {28'd0, perf_mispred}, 32'd3);

    // 4: back-to-back resolves
    do_reset();
    drive(i_BGE, 32'hFFFF_FFFB, 32'hFFFF_FFFB, 32'h40, 32'h300, 1'b1);
    step();
    chk_res("bge", 1'b1, 1'b0, 32'h340);
    drive(i_BNE, 32'd7, 32'd7, 32'h40, 32'h304, 1'b1);
    step();
    chk_res("bne", 1'b0, 1'b1, 32'h308);
    drive(i_BGEU, 32'd0, 32'd1, 32'h40, 32'h308, 1'b1);
    step();
    chk_res("bgeu", 1'b0, 1'b1, 32'h30C);
    idle();
    step();
    chk("b2b_done_off", {31'd0, done}, 32'd0);
    chk("b2b_perf_br", {28'd0, perf_branches}, 32'd3);
    chk("b2b_perf_mp", {28'd0, perf_mispred}, 32'd2);

    // illegal encoding: no training, counted only as a mispredict
    drive(i_BEQ, 32'd1, 32'd1, 32'h8, 32'h410, 1'b0);
    step();
    drive(br_op_t'(3'b010), 32'd1, 32'd1, 32'h8, 32'h410, 1'b1);
    step();
    chk_res("illegal", 1'b0, 1'b1, 32'h414);
    idle();
    lookup_pc = 32'h410;
    step();
    chk("illegal_bht", {31'd0, lookup_taken}, 32'd1);
    chk("illegal_perf_br", {28'd0, perf_branches}, 32'd4);
    chk("illegal_perf_mp", {28'd0, perf_mispred}, 32'd4);

    // 5: flush kills the request entirely
    lookup_pc = 32'h20;
    drive(i_BEQ, 32'd3, 32'd3, 32'h8, 32'h20, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    idle();
    chk("flush_done", {31'd0, done}, 32'd0);
    chk("flush_bht", {31'd0, lookup_taken}, 32'd0);
    chk("flush_perf_br", {28'd0, perf_branches}, 32'd4);
    chk("flush_perf_mp", {28'd0, perf_mispred}, 32'd4);

    // reset beats a concurrent request
    lookup_pc = 32'h410;
    drive(i_BEQ, 32'd3, 32'd3, 32'h8, 32'h410, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    idle();
    chk("rstreq_done", {31'd0, done}, 32'd0);
    chk("rstreq_taken", {31'd0, taken}, 32'd0);
    chk("rstreq_mp", {31'd0, mispredict}, 32'd0);
    chk("rstreq_rpc", redirect_pc, 32'd0);
    chk("rstreq_perf_br", {28'd0, perf_branches}, 32'd0);
    chk("rstreq_bht", {31'd0, lookup_taken}, 32'd0);
    drive(i_BEQ, 32'd3, 32'd3, 32'h8, 32'h410, 1'b0);
    step();
    idle();
    chk("rstreq_bht01", {31'd0, lookup_taken}, 32'd1);

    // 6: PC adder wrap on both paths
    drive(i_BNE, 32'd1, 32'd1, 32'h8, 32'hFFFF_FFFC, 1'b0);
    step();
    chk_res("wrap_nt", 1'b0, 1'b0, 32'h0);
    drive(i_BEQ, 32'd1, 32'd1, 32'h8, 32'hFFFF_FFFC, 1'b1);
    step();
    chk_res("wrap_t", 1'b1, 1'b0, 32'h4);

    // perf counter saturation
    do_reset();
    drive(i_BEQ, 32'd2, 32'd2, 32'h8, 32'h500, 1'b0);
    for (int i = 0; i < 14; i++) step();
    chk("sat_pre_br", {28'd0, perf_branches}, 32'hE);
    chk("sat_pre_mp", {28'd0, perf_mispred}, 32'hE);
    for (int i = 0; i < 3; i++) step();
    idle();
    step();
    chk("sat_br", {28'd0, perf_branches}, 32'hF);
    chk("sat_mp", {28'd0, perf_mispred}, 32'hF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
